// File: rtl/yu_core_pkg.sv
// rtl/yu_core_pkg.sv - shared core constants and requester/pointer enums
package yu_core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_LSU = 1'b1
    } ptr_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requests, issue/query and register-file write bundle
interface regfile_wb_arbiter_if
    import yu_core_pkg::*;
#(
    parameter int XLEN = yu_core_pkg::XLEN
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;

    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [REG_ADDR_W-1:0] lsu_rd;
    logic [XLEN-1:0]       lsu_data;

    logic                  issue_en;
    logic [REG_ADDR_W-1:0] issue_rd;

    logic [REG_ADDR_W-1:0] q_a1;
    logic [REG_ADDR_W-1:0] q_a2;
    logic                  q_busy1;
    logic                  q_busy2;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_a3;
    logic [XLEN-1:0]       rf_wd;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        output issue_en, issue_rd, q_a1, q_a2,
        input  q_busy1, q_busy2,
        input  rf_we, rf_a3, rf_wd
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        input  issue_en, issue_rd, q_a1, q_a2,
        output q_busy1, q_busy2,
        output rf_we, rf_a3, rf_wd
    );

endinterface

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - two-requester writeback arbiter; YU_WB_ROUND_ROBIN_EN selects round-robin,
// otherwise fixed LSU priority
module wb_rr_arbiter
    import yu_core_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

`ifdef YU_WB_ROUND_ROBIN_EN
    ptr_e ptr_q;
    ptr_e ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= LAST_LSU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // On contention the requester that did not win last time is served.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        if (rst_n) begin
            if (valid[REQ_ALU] && (!valid[REQ_LSU] || ptr_q == LAST_LSU)) begin
                grant[REQ_ALU] = 1'b1;
            end else if (valid[REQ_LSU]) begin
                grant[REQ_LSU] = 1'b1;
            end
        end
        if (grant[REQ_ALU]) begin
            ptr_d = LAST_ALU;
        end else if (grant[REQ_LSU]) begin
            ptr_d = LAST_LSU;
        end
    end
`else
    logic unused_clk;
    assign unused_clk = clk;

    always_comb begin
        grant = '0;
        if (rst_n) begin
            if (valid[REQ_LSU]) begin
                grant[REQ_LSU] = 1'b1;
            end else if (valid[REQ_ALU]) begin
                grant[REQ_ALU] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - ALU/LSU writeback arbiter with busy scoreboard and registered
// register-file write port; YU_WB_ROUND_ROBIN_EN enables round-robin arbitration
module regfile_wb_arbiter
    import yu_core_pkg::*;
#(
    parameter int XLEN     = yu_core_pkg::XLEN,
    parameter int NUM_REGS = yu_core_pkg::NUM_REGS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  wb
);

    logic [1:0]            valid;
    logic [1:0]            grant;
    logic                  gnt_any;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_a3_q;
    logic [XLEN-1:0]       rf_wd_q;

    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    assign valid[REQ_ALU] = wb.alu_valid;
    assign valid[REQ_LSU] = wb.lsu_valid;

    wb_rr_arbiter u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (valid),
        .grant (grant)
    );

    assign wb.alu_ready = grant[REQ_ALU];
    assign wb.lsu_ready = grant[REQ_LSU];

    assign gnt_any  = |grant;
    assign sel_rd   = grant[REQ_LSU] ? wb.lsu_rd   : wb.alu_rd;
    assign sel_data = grant[REQ_LSU] ? wb.lsu_data : wb.alu_data;

    // Writes to x0 are accepted from the requester but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q <= 1'b0;
            rf_a3_q <= '0;
            rf_wd_q <= '0;
        end else begin
            rf_we_q <= gnt_any && (sel_rd != '0);
            if (gnt_any) begin
                rf_a3_q <= sel_rd;
                rf_wd_q <= sel_data;
            end
        end
    end

    assign wb.rf_we = rf_we_q;
    assign wb.rf_a3 = rf_a3_q;
    assign wb.rf_wd = rf_wd_q;

    // Issue is applied after the clear so a new producer of the same rd keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (gnt_any) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (wb.issue_en) begin
            busy_d[wb.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign wb.q_busy1 = busy_q[wb.q_a1];
    assign wb.q_busy2 = busy_q[wb.q_a2];

endmodule
